// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller blocks.
package dmem_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_FIX  = 2'd3
  } scrub_state_e;

  // Byte address of a word index relative to a region base.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [29:0] word);
    return base + {word, 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
import dmem_ctrl_pkg::*;

module sat_counter16 (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_scrub_arbiter.sv
// Shares the data-memory port between the pipeline (always first, zero latency) and a background ECC scrubber.
// SCRUB_WRITEBACK_EN: when defined, single-bit-corrected words are written back through the FIX state.
import dmem_ctrl_pkg::*;

module dmem_scrub_arbiter #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int          INTERVAL    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scrub_en,
  input  logic        clr,
  input  logic        pipe_req,
  input  logic        pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wd,
  output logic [31:0] pipe_rd,
  output logic        pipe_s_err,
  output logic        pipe_d_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_s_err,
  input  logic        mem_d_err,
  output logic        scrub_busy,
  output logic        pass_done,
  output logic [15:0] s_err_cnt,
  output logic [15:0] d_err_cnt,
  output logic [31:0] d_err_addr,
  output logic        d_err_valid
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int IVL_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IVL_W-1:0] IVL_LOAD = IVL_W'(INTERVAL - 1);

  scrub_state_e     state_q;
  scrub_state_e     state_d;
  logic [IVL_W-1:0] ivl_q;
  logic [IVL_W-1:0] ivl_d;
  logic [PTR_W-1:0] ptr_q;
  logic [31:0]      scrub_addr;
  logic             advance;
  logic             s_inc;
  logic             d_inc;
  logic             d_cap;
  logic             scrub_we;
  logic [31:0]      scrub_wd;

  assign scrub_addr = word_byte_addr(ADDR_BASE, 30'(ptr_q));

`ifdef SCRUB_WRITEBACK_EN
  logic [31:0] fix_q;
  logic        fix_load;
  logic        fix_hit;

  // A pipeline store to the word being fixed carries newer data, so the fix is dropped.
  assign fix_hit  = pipe_req && pipe_we && (pipe_addr[31:2] == scrub_addr[31:2]);
  assign scrub_we = (state_q == ST_FIX);
  assign scrub_wd = scrub_we ? fix_q : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fix_q <= '0;
    end else if (fix_load) begin
      fix_q <= mem_rd;
    end
  end
`else
  assign scrub_we = 1'b0;
  assign scrub_wd = 32'h0;
`endif

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    advance = 1'b0;
    s_inc   = 1'b0;
    d_inc   = 1'b0;
    d_cap   = 1'b0;
`ifdef SCRUB_WRITEBACK_EN
    fix_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (scrub_en) begin
          state_d = ST_WAIT;
          ivl_d   = IVL_LOAD;
        end
      end
      ST_WAIT: begin
        if (!scrub_en) begin
          state_d = ST_IDLE;
        end else if (ivl_q == '0) begin
          state_d = ST_READ;
        end else begin
          ivl_d = ivl_q - 1'b1;
        end
      end
      ST_READ: begin
        if (!scrub_en) begin
          state_d = ST_IDLE;
        end else if (!pipe_req) begin
          if (mem_d_err) begin
            d_inc   = 1'b1;
            d_cap   = !d_err_valid;
            advance = 1'b1;
          end else if (mem_s_err) begin
            s_inc = 1'b1;
`ifdef SCRUB_WRITEBACK_EN
            fix_load = 1'b1;
            state_d  = ST_FIX;
`else
            advance = 1'b1;
`endif
          end else begin
            advance = 1'b1;
          end
        end
      end
`ifdef SCRUB_WRITEBACK_EN
      ST_FIX: begin
        if (!pipe_req || fix_hit) begin
          advance = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      state_d = ST_WAIT;
      ivl_d   = IVL_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ivl_q     <= '0;
      ptr_q     <= '0;
      pass_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ivl_q     <= ivl_d;
      pass_done <= advance && (ptr_q == '1);
      if (advance) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // Only the first double-bit error is logged until software clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_err_valid <= 1'b0;
      d_err_addr  <= '0;
    end else if (clr) begin
      d_err_valid <= 1'b0;
    end else if (d_cap) begin
      d_err_valid <= 1'b1;
      d_err_addr  <= scrub_addr;
    end
  end

  sat_counter16 u_s_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (s_inc),
    .cnt (s_err_cnt)
  );

  sat_counter16 u_d_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (d_inc),
    .cnt (d_err_cnt)
  );

  assign mem_we     = pipe_req ? pipe_we   : scrub_we;
  assign mem_addr   = pipe_req ? pipe_addr : scrub_addr;
  assign mem_wd     = pipe_req ? pipe_wd   : scrub_wd;
  assign pipe_rd    = mem_rd;
  assign pipe_s_err = pipe_req & mem_s_err;
  assign pipe_d_err = pipe_req & mem_d_err;
  assign scrub_busy = (state_q != ST_IDLE);

endmodule
